// File: rtl/cache_mem_arbiter.sv
// Arbitrates one SRAM-like memory port between the i-cache and d-cache.
// One transaction in flight; the granted request is latched at grant time.
module cache_mem_arbiter #(
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;
    logic   gnt_d;
    logic   last_d;
    logic   any_req;
    logic   pick_d;
    logic   grant;
    logic   addr_hit;
    logic   done;

    // Winner selection; on a tie the d-side wins unless round-robin says otherwise.
    always_comb begin
        any_req = inst_req | data_req;
        pick_d  = data_req & (~inst_req | D_PRIORITY | ~last_d);
        grant   = (state == IDLE) & any_req;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake strobes; strobes follow the memory side combinationally.
    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        addr_hit = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    addr_hit = 1'b1;
                    if (mem_data_ok) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Latch the winning request so the requester may move on after addr_ok.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_d     <= 1'b0;
            last_d    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_size  <= 2'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else if (grant) begin
            gnt_d     <= pick_d;
            last_d    <= pick_d;
            mem_wr    <= pick_d ? data_wr    : inst_wr;
            mem_size  <= pick_d ? data_size  : inst_size;
            mem_addr  <= pick_d ? data_addr  : inst_addr;
            mem_wdata <= pick_d ? data_wdata : inst_wdata;
        end
    end

    // Steer strobes to the granted side only; read data is shared.
    always_comb begin
        inst_addr_ok = addr_hit & ~gnt_d;
        inst_data_ok = done & ~gnt_d;
        data_addr_ok = addr_hit & gnt_d;
        data_data_ok = done & gnt_d;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

endmodule
